// File: rtl/sdram_ctrl_sub_model.sv
// On-chip RAM responder for the subordinate side of sdram_ctrl_if with SDRAM-like latency and refresh stalls.
// Optional SDRAM_SUB_RANGE_CHECK_EN adds an err output and disables address wrap-around.
module sdram_ctrl_sub_model #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_WORDS        = 1024,
  parameter int RD_LATENCY       = 4,
  parameter int WR_LATENCY       = 2,
  parameter int REFRESH_INTERVAL = 390,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  rdy,
  output logic                  wvalid,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] read_data,
`ifdef SDRAM_SUB_RANGE_CHECK_EN
  output logic                  err,
`endif
  output logic [1:0]            dbg_state
);

  // Handshake: a request is taken on a clock edge where rdy && (wr || rd); wr/rd are levels held
  // by the manager until taken. wvalid/rvalid are single-cycle completion pulses, no back-pressure.

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int WIDX_W     = ADDR_WIDTH - BYTE_SHIFT;
  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam int MAX_LAT    = (RD_LATENCY > WR_LATENCY) ?
                              ((RD_LATENCY > REFRESH_CYCLES) ? RD_LATENCY : REFRESH_CYCLES) :
                              ((WR_LATENCY > REFRESH_CYCLES) ? WR_LATENCY : REFRESH_CYCLES);
  localparam int CNT_W      = $clog2(MAX_LAT + 1);
  localparam int REF_W      = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_LATENCY);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] RD_PRE   = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_READ    = 2'd2,
    S_REFRESH = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        lat_cnt;
  logic                    ref_pending;
  logic                    ref_wrap;
  logic                    run_q;
  logic                    accept_wr;
  logic                    accept_rd;
  logic [WIDX_W-1:0]       word_idx;
  logic [IDX_W-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
  logic                    unused_bits;

  assign word_idx    = addr[ADDR_WIDTH-1:BYTE_SHIFT];
  assign mem_idx     = word_idx[IDX_W-1:0];
  assign unused_bits = ^{addr, word_idx};

  assign accept_wr = rdy && wr;
  assign accept_rd = rdy && rd && !wr;

`ifdef SDRAM_SUB_RANGE_CHECK_EN
  function automatic logic [DATA_WIDTH-1:0] fill_pattern();
    logic [31:0]           word;
    logic [DATA_WIDTH-1:0] v;
    word = 32'hDEADBEEF;
    v    = '0;
    for (int i = 0; i < DATA_WIDTH; i++) v[i] = word[i % 32];
    return v;
  endfunction

  localparam logic [DATA_WIDTH-1:0] OOB_DATA = fill_pattern();

  logic oob;
  logic oob_q;

  assign oob = (word_idx >> IDX_W) != '0;

  always_ff @(posedge clk) begin
    if (rst) oob_q <= 1'b0;
    else if (accept_wr || accept_rd) oob_q <= oob;
  end
`else
  logic oob;
  assign oob = 1'b0;
`endif

  // Refresh timer free-runs from reset; interval 0 removes it entirely.
  generate
    if (REFRESH_INTERVAL > 0) begin : g_ref
      logic [REF_W-1:0] ref_cnt;
      assign ref_wrap = (ref_cnt == REF_W'(REFRESH_INTERVAL - 1));
      always_ff @(posedge clk) begin
        if (rst) ref_cnt <= '0;
        else if (ref_wrap) ref_cnt <= '0;
        else ref_cnt <= ref_cnt + 1'b1;
      end
    end else begin : g_no_ref
      assign ref_wrap = 1'b0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_next;
  end

  // Next-state logic. A wrap seen while idle with no request goes straight to refresh.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (ref_pending) state_next = S_REFRESH;
        else if (accept_wr) state_next = S_WRITE;
        else if (accept_rd) state_next = S_READ;
        else if (ref_wrap) state_next = S_REFRESH;
      end
      S_WRITE:   if (lat_cnt == WR_LAST) state_next = S_IDLE;
      S_READ:    if (lat_cnt == RD_LAST) state_next = S_IDLE;
      S_REFRESH: if (lat_cnt == REF_LAST) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are derived from registers only.
  always_comb begin
    rdy       = run_q && (state == S_IDLE) && !ref_pending;
    wvalid    = (state == S_WRITE) && (lat_cnt == WR_LAST);
    rvalid    = (state == S_READ) && (lat_cnt == RD_LAST);
    dbg_state = state;
`ifdef SDRAM_SUB_RANGE_CHECK_EN
    err       = oob_q && (wvalid || rvalid);
`endif
  end

  // Keeps rdy low for the whole reset without a combinational path from rst.
  always_ff @(posedge clk) begin
    run_q <= !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt     <= '0;
      ref_pending <= 1'b0;
      read_data   <= '0;
    end else begin
      if (state != state_next) lat_cnt <= '0;
      else if (state != S_IDLE) lat_cnt <= lat_cnt + 1'b1;

      if (state == S_IDLE && state_next == S_REFRESH) ref_pending <= 1'b0;
      else if (ref_wrap) ref_pending <= 1'b1;

      if (state == S_READ && lat_cnt == RD_PRE) read_data <= hold_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_wr && !rst && !oob) mem[mem_idx] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (accept_rd) begin
`ifdef SDRAM_SUB_RANGE_CHECK_EN
      hold_q <= oob ? OOB_DATA : mem[mem_idx];
`else
      hold_q <= mem[mem_idx];
`endif
    end
  end

endmodule

// File: tb/tb_sdram_ctrl_sub_model.sv
// Directed bench for sdram_ctrl_sub_model: timing, refresh stalls, wrap/range handling, reset abort.
// Builds with or without SDRAM_SUB_RANGE_CHECK_EN.
module tb_sdram_ctrl_sub_model;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 16;
  localparam int RL = 4;
  localparam int WL = 2;
  localparam int RI = 20;
  localparam int RC = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data;
  logic          wr;
  logic          rd;
  logic          rdy;
  logic          wvalid;
  logic          rvalid;
  logic [DW-1:0] read_data;
  logic [1:0]    dbg_state;
`ifdef SDRAM_SUB_RANGE_CHECK_EN
  logic          err;
`endif

  int checks = 0;
  int failures = 0;
  int wvalid_seen = 0;
  int writes_issued = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model[MW];

  sdram_ctrl_sub_model #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .RD_LATENCY(RL),
    .WR_LATENCY(WL), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data), .wr(wr), .rd(rd),
    .rdy(rdy), .wvalid(wvalid), .rvalid(rvalid), .read_data(read_data),
`ifdef SDRAM_SUB_RANGE_CHECK_EN
    .err(err),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_oob(input logic [AW-1:0] a);
`ifdef SDRAM_SUB_RANGE_CHECK_EN
    return (a >> 2) >= AW'(MW);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    return is_oob(a) ? 32'hDEADBEEF : model[widx(a)];
  endfunction

  // Scoreboard: every rvalid pops one expected word.
  always @(negedge clk) begin
    if (wvalid === 1'b1) wvalid_seen++;
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) chk1("rvalid_unexpected", rvalid, 1'b0);
      else chkw("read_data", read_data, exp_q.pop_front());
    end
  end

  // Driver tasks; all start and end at a negedge.
  task automatic wait_accept(output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      if (rdy === 1'b1) ok = 1'b1;
      @(negedge clk);
      n++;
    end
    chk1("accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_rdy(input logic lvl, output int n);
    n = 0;
    while (rdy !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("rdy_level_timeout", rdy, lvl);
  endtask

  task automatic track_write();
    for (int k = 0; k <= WL + 1; k++) begin
      if (k > 0) @(negedge clk);
      chk1($sformatf("wvalid_k%0d", k), wvalid, k == WL);
      chk1($sformatf("wr_rvalid_k%0d", k), rvalid, 1'b0);
      if (k <= WL) chk1($sformatf("wr_rdy_busy_k%0d", k), rdy, 1'b0);
`ifdef SDRAM_SUB_RANGE_CHECK_EN
      chk1($sformatf("wr_err_k%0d", k), err, (k == WL) && is_oob(addr));
`endif
    end
  endtask

  task automatic track_read(input logic [DW-1:0] e);
    for (int k = 0; k <= RL + 1; k++) begin
      if (k > 0) @(negedge clk);
      chk1($sformatf("rvalid_k%0d", k), rvalid, k == RL);
      if (k <= RL) chk1($sformatf("rd_rdy_busy_k%0d", k), rdy, 1'b0);
`ifdef SDRAM_SUB_RANGE_CHECK_EN
      chk1($sformatf("rd_err_k%0d", k), err, (k == RL) && is_oob(addr));
`endif
    end
    chkw("read_data_hold", read_data, e);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    int n;
    addr = a;
    write_data = d;
    wr = 1'b1;
    wait_accept(ok, n);
    wr = 1'b0;
    if (ok) begin
      if (!is_oob(a)) model[widx(a)] = d;
      writes_issued++;
      track_write();
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bit ok;
    int n;
    logic [DW-1:0] e;
    addr = a;
    rd = 1'b1;
    wait_accept(ok, n);
    rd = 1'b0;
    if (ok) begin
      e = exp_read(a);
      exp_q.push_back(e);
      track_read(e);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk1("rst_rdy", rdy, 1'b0);
      chk1("rst_wvalid", wvalid, 1'b0);
      chk1("rst_rvalid", rvalid, 1'b0);
      chkw("rst_read_data", read_data, '0);
      chki("rst_state", int'(dbg_state), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk1("rdy_after_reset", rdy, 1'b1);
  endtask

  initial begin
    bit ok;
    int n;
    int n_low;
    int n_high;
    logic [AW-1:0] a;

    addr = '0;
    write_data = '0;
    wr = 1'b0;
    rd = 1'b0;
    do_reset(3);

    // Fill and read back all words, ten passes with distinct data.
    for (int rep = 0; rep < 10; rep++) begin
      for (int i = 0; i < MW; i++)
        do_write(AW'(i << 2), 32'hab00cd00 + DW'(i << 16) + DW'(i) + DW'(rep << 8));
      for (int i = 0; i < MW; i++)
        do_read(AW'(i << 2));
    end

    // Idle refresh: duration and period.
    wait_rdy(1'b1, n);
    wait_rdy(1'b0, n);
    wait_rdy(1'b1, n_low);
    chki("refresh_low_cycles", n_low, RC);
    wait_rdy(1'b0, n_high);
    chki("refresh_period_high", n_high, RI - RC);

    // Write held from the first refresh cycle is taken at the first idle cycle after it.
    addr = 32'h0000_0014;
    write_data = 32'hCAFE_0005;
    wr = 1'b1;
    wait_accept(ok, n);
    wr = 1'b0;
    chki("refresh_accept_wait", n, RC + 1);
    if (ok) begin
      model[widx(32'h14)] = 32'hCAFE_0005;
      writes_issued++;
      track_write();
    end
    do_read(32'h0000_0014);

    // wr and rd together: write first, then the held read.
    addr = 32'h0000_0040;
    write_data = 32'h1234_5678;
    wr = 1'b1;
    rd = 1'b1;
    wait_accept(ok, n);
    wr = 1'b0;
    if (ok) begin
      if (!is_oob(addr)) model[widx(addr)] = 32'h1234_5678;
      writes_issued++;
      track_write();
    end
    wait_accept(ok, n);
    rd = 1'b0;
    if (ok) begin
      exp_q.push_back(exp_read(32'h40));
      track_read(exp_read(32'h40));
    end

    // Wrap-around (or range error with the option).
    do_write(32'h0000_0040, 32'hA5A5_A5A5);
    do_read(32'h0000_0000);
    do_read(32'h0000_0040);

    // Reset one cycle after a read accept abandons it.
    addr = 32'h0000_0008;
    rd = 1'b1;
    wait_accept(ok, n);
    rd = 1'b0;
    do_reset(3);
    for (int i = 0; i < RL + 2; i++) begin
      chk1("abandoned_rvalid", rvalid, 1'b0);
      @(negedge clk);
    end
    do_read(32'h0000_0008);

    // Random in-range traffic.
    for (int i = 0; i < 24; i++) begin
      a = AW'($urandom_range(0, MW - 1)) << 2;
      if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom));
      else do_read(a);
    end

    repeat (RL + 2) @(negedge clk);
    chki("scoreboard_drained", exp_q.size(), 0);
    chki("wvalid_pulses", wvalid_seen, writes_issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
